nn_axil_intr_slave: RTL

NN_AXIL_INTR_SLAVE -- requirements
Module: nn_axil_intr_slave

---
 rtl/nn_axil_intr_slave.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nn_axil_intr_slave.sv
// AXI4-Lite interrupt controller for the NN core: GIE/IER/ISR/IAR/IPR registers,
// per-source level or rising-edge detection, and a registered irq output.
module nn_axil_intr_slave #(
  parameter int unsigned C_NUM_OF_INTR      = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFF_FFFF,
  parameter logic        C_IRQ_ACTIVE_STATE = 1'b1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]      intr_src,
  output logic                          irq
);

  localparam logic [31:0] IntrMask = 32'hFFFF_FFFF >> (32 - C_NUM_OF_INTR);

  localparam logic [2:0] OffGie = 3'd0;
  localparam logic [2:0] OffIer = 3'd1;
  localparam logic [2:0] OffIsr = 3'd2;
  localparam logic [2:0] OffIar = 3'd3;
  localparam logic [2:0] OffIpr = 3'd4;

  logic        wready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q;
  logic        gie_q, gie_d;
  logic [31:0] ier_q, ier_d;
  logic [31:0] isr_q, isr_d;
  logic [31:0] prev_q;
  logic        irq_q, irq_d;

  logic        wr_fire, rd_fire;
  logic [31:0] strb_bits, clr_bits, src_ext, event_bits, rd_word;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign wr_fire = wready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = arready_q & S_AXI_ARVALID;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      strb_bits[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    end
  end

  // Level sources fire while high; edge sources only on a 0->1 transition.
  assign src_ext    = 32'(intr_src);
  assign event_bits = ((src_ext & C_INTR_SENSITIVITY) |
                       (src_ext & ~prev_q & ~C_INTR_SENSITIVITY)) & IntrMask;

  always_comb begin
    gie_d    = gie_q;
    ier_d    = ier_q;
    clr_bits = '0;
    if (wr_fire) begin
      case (S_AXI_AWADDR[4:2])
        OffGie: if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
        OffIer: ier_d = ((ier_q & ~strb_bits) | (S_AXI_WDATA & strb_bits)) & IntrMask;
        OffIar: clr_bits = S_AXI_WDATA & strb_bits;
        default: ;
      endcase
    end
    // A new event on the same edge as a clear keeps the bit set.
    isr_d = ((isr_q & ~clr_bits) | event_bits) & IntrMask;
    irq_d = (gie_q && |(isr_q & ier_q)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
  end

  always_comb begin
    case (S_AXI_ARADDR[4:2])
      OffGie:  rd_word = {31'b0, gie_q};
      OffIer:  rd_word = ier_q;
      OffIsr:  rd_word = isr_q;
      OffIpr:  rd_word = isr_q & ier_q;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      gie_q     <= 1'b0;
      ier_q     <= '0;
      isr_q     <= '0;
      prev_q    <= '0;
      irq_q     <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      wready_q <= ~wready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      gie_q  <= gie_d;
      ier_q  <= ier_d;
      isr_q  <= isr_d;
      prev_q <= src_ext & IntrMask;
      irq_q  <= irq_d;
    end
  end

  assign S_AXI_AWREADY = wready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign irq           = irq_q;

endmodule
